seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width; legal values are 2 to 32.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request pulse or level; sampled only in IDLE.
REQ-005 SignedMode  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-006 Dividend  input  WIDTH  numerator; captured on the Start edge.
REQ-007 Divisor  input  WIDTH  denominator; captured on the Start edge.
REQ-008 Ack  input  1  consumer has taken the result; releases DONE.
REQ-009 Busy  output  1  high in every state except IDLE.
REQ-010 ResultValid  output  1  high only in DONE.
REQ-011 Quotient  output  WIDTH  result; zero outside DONE.
REQ-012 Remainder  output  WIDTH  result; zero outside DONE.
REQ-013 DivByZero  output  1  flag, valid in DONE; zero outside DONE.
REQ-014 Overflow  output  1  signed most-negative/-1 flag, valid in DONE; zero outside DONE.

Function
REQ-015 The state machine SHALL have the states IDLE, LOAD, CALC, FIX and DONE, all registered.
REQ-016 IDLE->LOAD SHALL occur when Start=1 at a clock edge; Dividend, Divisor and SignedMode are registered on that edge.
REQ-017 In LOAD, a zero divisor SHALL cause LOAD->DONE; otherwise the path is LOAD->CALC.
REQ-018 In LOAD, magnitudes SHALL be formed: negate any operand whose MSB is 1 when SignedMode=1, and pass operands unchanged when SignedMode=0; the result signs are stored.
REQ-019 CALC SHALL perform restoring division, one quotient bit per cycle, for exactly WIDTH cycles, using a WIDTH-bit counter cleared in LOAD; then CALC->FIX.
REQ-020 Each CALC step SHALL:
- shift the {A,Q} pair left;
- compute trial = A - D using a WIDTH+1-bit partial remainder A;
- on trial < 0, restore A and set q0=0;
- otherwise set A=trial and q0=1.
REQ-021 The WIDTH+1-bit partial remainder SHALL be used so that results are correct for the full unsigned range (e.g. 255/1, 200/201).
REQ-022 FIX SHALL, when SignedMode=1:
- negate the quotient if the signs differ;
- negate the remainder if the dividend was negative (truncating division, remainder takes the dividend's sign).
The state then moves FIX->DONE.
REQ-023 When SignedMode=0, FIX SHALL pass the results unchanged, so latency does not depend on mode.
REQ-024 Latency: for a Start edge at cycle k, ResultValid SHALL first be high in cycle k+WIDTH+3 when the divisor is nonzero, and in cycle k+2 when the divisor is zero.
REQ-025 Divide by zero SHALL produce Quotient = all ones, Remainder = captured Dividend, DivByZero=1 and Overflow=0, in both modes.
REQ-026 For SignedMode=1 with Dividend = most negative and Divisor = -1, the block SHALL produce Quotient = most negative (wrap), Remainder=0 and Overflow=1.
REQ-027 DONE SHALL hold all outputs stable until Ack=1 at an edge, then DONE->IDLE; Ack in any other state SHALL be ignored.
REQ-028 Start outside IDLE SHALL be ignored and SHALL not corrupt the captured operands.
REQ-029 Start and Ack both high in DONE SHALL return the block to IDLE only; a new operation SHALL require Start in IDLE.
REQ-030 Operand inputs SHALL be allowed to change freely after the capture edge without affecting the result.

Reset
REQ-031 Reset=1 at an edge SHALL force IDLE and clear the counter, operand registers, A and Q, from any state including mid-CALC.
REQ-032 After reset, Busy, ResultValid, Quotient, Remainder, DivByZero and Overflow SHALL all read 0.
REQ-033 Reset SHALL take priority over Start and Ack in the same cycle.

Verification (WIDTH=8)
REQ-034 Unsigned 100/7 -> Quotient=0x0E, Remainder=0x02, ResultValid in cycle k+11, flags 0.
REQ-035 Unsigned 255/1 and 200/201 -> Q=0xFF, R=0x00; then Q=0x00, R=0xC8.
REQ-036 Signed -7/2 (0xF9/0x02) -> Q=0xFD, R=0xFF; signed 7/-2 -> Q=0xFD, R=0x01.
REQ-037 Divisor 0 with Dividend 0x55 -> Q=0xFF, R=0x55, DivByZero=1, ResultValid in cycle k+2.
REQ-038 Signed 0x80/0xFF -> Q=0x80, R=0x00, Overflow=1; outputs held through 5 cycles without Ack, IDLE one cycle after Ack.
REQ-039 Reset asserted at the 4th CALC cycle, then Start with Start pulses injected while Busy -> outputs 0 after reset, injected pulses ignored, next 100/7 correct.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed or unsigned.
//   A Start in IDLE captures Dividend, Divisor and SignedMode.
//   LOAD forms the operand magnitudes. CALC produces one quotient bit per cycle
//   for WIDTH cycles. FIX applies the result signs. DONE holds the result until Ack.
// Ports:
//   i_Clock, i_Reset          rising-edge clock; synchronous active-high reset
//   i_Start, i_SignedMode     request; operand mode (1 = two's complement)
//   i_Dividend, i_Divisor     WIDTH-bit operands, captured on the Start edge
//   i_Ack                     consumer took the result; releases DONE
//   o_Busy                    high in every state except IDLE
//   o_ResultValid             high only in DONE
//   o_Quotient, o_Remainder   results; zero outside DONE
//   o_DivByZero, o_Overflow   status flags; zero outside DONE
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_SignedMode,
  input  logic [WIDTH-1:0] i_Dividend,
  input  logic [WIDTH-1:0] i_Divisor,
  input  logic             i_Ack,
  output logic             o_Busy,
  output logic             o_ResultValid,
  output logic [WIDTH-1:0] o_Quotient,
  output logic [WIDTH-1:0] o_Remainder,
  output logic             o_DivByZero,
  output logic             o_Overflow
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_State;
  logic [WIDTH-1:0] r_Dvd, r_Dvs;        // captured operands
  logic             r_Signed;
  logic [WIDTH:0]   r_A;                 // partial remainder, one spare bit
  logic [WIDTH-1:0] r_Q;                 // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_D;                 // divisor magnitude
  logic [WIDTH-1:0] r_Count;
  logic             r_QNeg, r_RNeg;      // result signs

  logic             w_DvdNeg, w_DvsNeg;
  logic [WIDTH-1:0] w_DvdMag, w_DvsMag;
  logic [WIDTH:0]   w_AShift, w_Trial;
  logic [WIDTH-1:0] w_QFix, w_RFix;
  logic             w_Ovf;

  assign w_DvdNeg = r_Signed & r_Dvd[WIDTH-1];
  assign w_DvsNeg = r_Signed & r_Dvs[WIDTH-1];
  assign w_DvdMag = w_DvdNeg ? (~r_Dvd + ONE) : r_Dvd;
  assign w_DvsMag = w_DvsNeg ? (~r_Dvs + ONE) : r_Dvs;

  // A < D holds before every step, so the shifted value is below 2*D.
  // A WIDTH+1-bit result is therefore enough, and its top bit is the sign
  // of the trial subtraction.
  assign w_AShift = {r_A[WIDTH-1:0], r_Q[WIDTH-1]};
  assign w_Trial  = w_AShift - {1'b0, r_D};

  assign w_QFix = r_QNeg ? (~r_Q + ONE) : r_Q;
  assign w_RFix = r_RNeg ? (~r_A[WIDTH-1:0] + ONE) : r_A[WIDTH-1:0];
  // The most-negative quotient wraps back to itself when negated.
  // Only the flag marks this case.
  assign w_Ovf  = r_Signed & (r_Dvd == MOSTNEG) & (r_Dvs == '1);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State       <= S_IDLE;
      r_Dvd         <= '0;
      r_Dvs         <= '0;
      r_Signed      <= 1'b0;
      r_A           <= '0;
      r_Q           <= '0;
      r_D           <= '0;
      r_Count       <= '0;
      r_QNeg        <= 1'b0;
      r_RNeg        <= 1'b0;
      o_Busy        <= 1'b0;
      o_ResultValid <= 1'b0;
      o_Quotient    <= '0;
      o_Remainder   <= '0;
      o_DivByZero   <= 1'b0;
      o_Overflow    <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: if (i_Start) begin
          r_Dvd    <= i_Dividend;
          r_Dvs    <= i_Divisor;
          r_Signed <= i_SignedMode;
          o_Busy   <= 1'b1;
          r_State  <= S_LOAD;
        end
        S_LOAD: begin
          r_Count <= '0;
          r_A     <= '0;
          r_Q     <= w_DvdMag;
          r_D     <= w_DvsMag;
          r_QNeg  <= w_DvdNeg ^ w_DvsNeg;
          r_RNeg  <= w_DvdNeg;
          if (r_Dvs == '0) begin
            o_Quotient    <= '1;
            o_Remainder   <= r_Dvd;
            o_DivByZero   <= 1'b1;
            o_Overflow    <= 1'b0;
            o_ResultValid <= 1'b1;
            r_State       <= S_DONE;
          end else begin
            r_State <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_Trial[WIDTH]) begin
            r_A <= w_AShift;
            r_Q <= {r_Q[WIDTH-2:0], 1'b0};
          end else begin
            r_A <= w_Trial;
            r_Q <= {r_Q[WIDTH-2:0], 1'b1};
          end
          r_Count <= r_Count + ONE;
          if (r_Count == LAST) r_State <= S_FIX;
        end
        S_FIX: begin
          o_Quotient    <= w_QFix;
          o_Remainder   <= w_RFix;
          o_DivByZero   <= 1'b0;
          o_Overflow    <= w_Ovf;
          o_ResultValid <= 1'b1;
          r_State       <= S_DONE;
        end
        S_DONE: if (i_Ack) begin
          o_Busy        <= 1'b0;
          o_ResultValid <= 1'b0;
          o_Quotient    <= '0;
          o_Remainder   <= '0;
          o_DivByZero   <= 1'b0;
          o_Overflow    <= 1'b0;
          r_State       <= S_IDLE;
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8) with hand-computed expected values.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst, start, sm, ack;
  logic [7:0] dvd, dvs;
  logic       busy, rv, dz, ov;
  logic [7:0] q, r;
  int checks = 0;
  int failures = 0;
  int lat;

  seq_divider #(.WIDTH(8)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_SignedMode(sm),
    .i_Dividend(dvd), .i_Divisor(dvs), .i_Ack(ack),
    .o_Busy(busy), .o_ResultValid(rv), .o_Quotient(q), .o_Remainder(r),
    .o_DivByZero(dz), .o_Overflow(ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Start one division and return the number of cycles until ResultValid.
  // The Start edge counts as k, so the first negedge is in cycle k+1.
  // With inj set, stray Start and Ack pulses are driven while the block is busy.
  task automatic run_div(input logic m, input logic [7:0] a, input logic [7:0] b,
                         input bit inj, output int n);
    @(negedge clk);
    sm = m; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sm = ~m; dvd = 8'($urandom); dvs = 8'($urandom);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rv) break;
      if (inj) begin
        if (n == 3) begin start = 1'b1; dvd = 8'h11; dvs = 8'h03; end
        if (n == 4) start = 1'b0;
        if (n == 5) ack = 1'b1;
        if (n == 6) ack = 1'b0;
      end
    end
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rv"}, rv, 0);
    chk({tag, "_q"}, q, 0);
  endtask

  task automatic res(input string tag, input int l, input logic [7:0] eq, input logic [7:0] er,
                     input logic edz, input logic eov);
    chk({tag, "_lat"}, l, (edz ? 2 : 11));
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, dz, edz);
    chk({tag, "_ov"}, ov, eov);
    chk({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sm = 1'b0; ack = 1'b0; dvd = '0; dvs = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {busy, rv, q, r, dz, ov}, 0);

    run_div(1'b0, 8'd100, 8'd7, 1'b0, lat);   res("u100_7", lat, 8'h0E, 8'h02, 0, 0); do_ack("u100_7a");
    run_div(1'b0, 8'd255, 8'd1, 1'b0, lat);   res("u255_1", lat, 8'hFF, 8'h00, 0, 0); do_ack("u255_1a");
    run_div(1'b0, 8'd200, 8'd201, 1'b0, lat); res("u200_201", lat, 8'h00, 8'hC8, 0, 0); do_ack("u200a");
    run_div(1'b1, 8'hF9, 8'h02, 1'b0, lat);   res("s_m7_2", lat, 8'hFD, 8'hFF, 0, 0); do_ack("sm7a");
    run_div(1'b1, 8'h07, 8'hFE, 1'b0, lat);   res("s_7_m2", lat, 8'hFD, 8'h01, 0, 0); do_ack("s7a");
    run_div(1'b0, 8'h55, 8'h00, 1'b0, lat);   res("u_dz", lat, 8'hFF, 8'h55, 1, 0); do_ack("udza");
    run_div(1'b1, 8'h80, 8'h00, 1'b0, lat);   res("s_dz", lat, 8'hFF, 8'h80, 1, 0); do_ack("sdza");

    // Overflow case: result must be held without Ack.
    // Start together with Ack then only returns the block to IDLE.
    run_div(1'b1, 8'h80, 8'hFF, 1'b0, lat);   res("s_ovf", lat, 8'h80, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold", {rv, q, r, ov}, {1'b1, 8'h80, 8'h00, 1'b1});
    end
    @(negedge clk); start = 1'b1; ack = 1'b1;
    @(posedge clk); #1 start = 1'b0; ack = 1'b0;
    @(negedge clk); chk("sa_idle", {busy, rv}, 0);
    @(negedge clk); chk("sa_nostart", busy, 0);

    // Reset during the 4th CALC cycle (k+5), with Start and Ack also high.
    @(negedge clk); sm = 1'b0; dvd = 8'd100; dvs = 8'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midcalc_busy", busy, 1);
    rst = 1'b1; start = 1'b1; ack = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0; ack = 1'b0;
    @(negedge clk);
    chk("midrst_out", {busy, rv, q, r, dz, ov}, 0);
    @(negedge clk); chk("midrst_idle", busy, 0);

    run_div(1'b0, 8'd100, 8'd7, 1'b1, lat);   res("inj100_7", lat, 8'h0E, 8'h02, 0, 0); do_ack("inja");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
